// File: rtl/uart_pkg.sv
// Shared UART types: the received-byte width and the byte typedef used by the
// receive path and its buffer.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage : uart_pkg

// File: rtl/uart_rx_fifo_mem.sv
// Register-array storage for the UART receive FIFO: one synchronous write port
// and one asynchronous read port. The array is deliberately not reset.
module fifo_mem #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Synchronous write of one entry per enabled cycle
    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule : fifo_mem

// File: rtl/uart_rx_fifo.sv
// Byte buffer behind the UART receiver: captures a byte on every completion
// strobe, hands bytes out over valid/ready, and reports fill level and overflow.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = UART_DATA_W
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [WIDTH-1:0]         rx_data,
    input  logic                     rx_strobe,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     overflow,
    input  logic                     overflow_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [LW-1:0] LVL_ONE    = LW'(1);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             overflow_q, overflow_d;
    logic             push_s, pop_s, drop_s;
    logic [WIDTH-1:0] head_s;

    assign rd_valid = (level_q != {LW{1'b0}});
    assign full     = (level_q == FULL_LEVEL);
    assign level    = level_q;
    assign overflow = overflow_q;
    assign rd_data  = rd_valid ? head_s : {WIDTH{1'b0}};

    // A full FIFO still accepts a byte when the head leaves in the same cycle
    assign pop_s  = rd_valid && rd_ready;
    assign push_s = rx_strobe && (!full || pop_s);
    assign drop_s = rx_strobe && !push_s;

    fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clock (clock),
        .we    (push_s),
        .waddr (wr_ptr_q),
        .wdata (rx_data),
        .raddr (rd_ptr_q),
        .rdata (head_s)
    );

    // Next-state for pointers, fill level and sticky overflow
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase

        // A new drop beats a concurrent clear
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Control state registers with asynchronous clear
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            level_q    <= {LW{1'b0}};
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a queue-based model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_uart_rx_fifo;

    localparam int DEPTH = 8;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] rx_data;
    logic       rx_strobe;
    logic       rd_ready;
    logic       overflow_clr;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic [3:0] level;
    logic       full;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    logic [7:0] mq[$];
    logic       m_ovf;

    uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(8)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .rx_data      (rx_data),
        .rx_strobe    (rx_strobe),
        .rd_ready     (rd_ready),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .level        (level),
        .full         (full),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: a bounded queue of bytes plus a sticky drop flag
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            bit do_pop, do_push;
            do_pop  = (mq.size() != 0) && rd_ready;
            do_push = rx_strobe && ((mq.size() < DEPTH) || do_pop);
            if (rx_strobe && !do_push) m_ovf = 1'b1;
            else if (overflow_clr)     m_ovf = 1'b0;
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(rx_data);
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clock) begin
        if (reset_n === 1'b1) begin
            chk("m_valid", rd_valid, (mq.size() != 0));
            chk("m_data", rd_data, (mq.size() != 0) ? mq[0] : 8'h00);
            chk("m_level", level, mq.size());
            chk("m_full", full, (mq.size() == DEPTH));
            chk("m_ovf", overflow, m_ovf);
        end
    end

    // Apply one cycle of inputs; returns at the next negedge
    task automatic drive(input logic s, input logic [7:0] d, input logic r, input logic c);
        rx_strobe    = s;
        rx_data      = d;
        rd_ready     = r;
        overflow_clr = c;
        @(negedge clock);
    endtask

    task automatic fill(input logic [7:0] base);
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, base + 8'(i), 1'b0, 1'b0);
            chk("fill_level", level, i + 1);
        end
        chk("fill_full", full, 1'b1);
    endtask

    task automatic drain(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            chk("drain_data", rd_data, base + 8'(i));
            chk("drain_level", level, n - i);
            drive(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("drain_empty", rd_valid, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0;
        rx_strobe = 1'b0; rx_data = 8'h00; rd_ready = 1'b0; overflow_clr = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("rst_valid", rd_valid, 1'b0);
        chk("rst_data", rd_data, 8'h00);
        chk("rst_level", level, 4'd0);
        chk("rst_full", full, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        reset_n = 1'b1;
        @(negedge clock);

        // Single byte in and out
        drive(1'b1, 8'hA5, 1'b0, 1'b0);
        chk("t1_valid", rd_valid, 1'b1);
        chk("t1_data", rd_data, 8'hA5);
        chk("t1_level", level, 4'd1);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t1_valid0", rd_valid, 1'b0);
        chk("t1_data0", rd_data, 8'h00);
        chk("t1_level0", level, 4'd0);

        // Fill/drain in order, then wrap the pointers mid-array
        fill(8'h00);
        drain(8'h00, 8);
        for (int i = 0; i < 3; i++) drive(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
        drain(8'h20, 3);
        fill(8'h30);
        drain(8'h30, 8);

        // Overflow drop while full
        fill(8'h40);
        drive(1'b1, 8'hFF, 1'b0, 1'b0);
        chk("t3_ovf", overflow, 1'b1);
        chk("t3_level", level, 4'd8);
        chk("t3_head", rd_data, 8'h40);
        drain(8'h40, 8);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t3_clr", overflow, 1'b0);

        // Full with simultaneous push and pop
        fill(8'h50);
        drive(1'b1, 8'h3C, 1'b1, 1'b0);
        chk("t4_ovf", overflow, 1'b0);
        chk("t4_level", level, 4'd8);
        for (int i = 0; i < 7; i++) begin
            chk("t4_data", rd_data, 8'h51 + 8'(i));
            drive(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("t4_last", rd_data, 8'h3C);
        chk("t4_lvl1", level, 4'd1);
        drive(1'b0, 8'h00, 1'b1, 1'b0);

        // Asynchronous reset mid-cycle with bytes queued
        drive(1'b1, 8'h61, 1'b0, 1'b0);
        drive(1'b1, 8'h62, 1'b0, 1'b0);
        rx_strobe = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("t5_valid", rd_valid, 1'b0);
        chk("t5_data", rd_data, 8'h00);
        chk("t5_level", level, 4'd0);
        chk("t5_full", full, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t5_empty", rd_valid, 1'b0);
        fill(8'h70);
        drive(1'b1, 8'hEE, 1'b0, 1'b1);
        chk("t5_setwins", overflow, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t5_clr", overflow, 1'b0);
        drain(8'h70, 8);

        // Back-to-back strobes with a consumer that is always ready
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'h80 + 8'(i), 1'b1, 1'b0);
            chk("t6_level", level, 4'd1);
            chk("t6_data", rd_data, 8'h80 + 8'(i));
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t6_done", level, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_uart_rx_fifo
